// File: rtl/fp6_pkg.sv
// Shared constants and types for the FP6 E2M3 / MX conversion blocks.
// Field widths follow BF16 (1/8/7) and E2M3 (1/2/3); E8M0 is a bare biased exponent.
package fp6_pkg;

    localparam int FP6_EXP_W = 2;
    localparam int FP6_MAN_W = 3;
    localparam int FP6_W     = 1 + FP6_EXP_W + FP6_MAN_W;
    localparam int FP6_EMAX  = 2;

    localparam logic [FP6_W-2:0] FP6_MAX_MAG = 5'b11111;
    localparam logic [7:0]       E8M0_NAN    = 8'hFF;

    localparam int BF16_EXP_W = 8;
    localparam int BF16_MAN_W = 7;
    localparam int BF16_W     = 1 + BF16_EXP_W + BF16_MAN_W;

    localparam logic [BF16_EXP_W-1:0] BF16_EXP_ONES = 8'hFF;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } quant_state_t;

endpackage

// File: rtl/fp6_e2m3_encode.sv
// Combinational BF16 -> FP6 E2M3 encoder against a shared E8M0 scale.
// Rounds to nearest even, saturates to the largest magnitude and flags saturation.
module fp6_e2m3_encode
    import fp6_pkg::*;
(
    input  logic [BF16_W-1:0] bf16,
    input  logic [7:0]        scale,
    output logic [FP6_W-1:0]  fp6,
    output logic              sat
);

    logic                  sign;
    logic [BF16_EXP_W-1:0] exp_b;
    logic [BF16_MAN_W-1:0] man;
    logic signed [9:0]     r;
    logic [2:0]            dshift;
    logic [1:0]            e_off;
    logic [11:0]           window;
    logic                  inc;
    logic [5:0]            sum;

    assign sign  = bf16[BF16_W-1];
    assign exp_b = bf16[BF16_W-2 -: BF16_EXP_W];
    assign man   = bf16[BF16_MAN_W-1:0];
    assign r     = $signed({2'b00, exp_b}) - $signed({2'b00, scale});

    // Normal results: hidden one sits at weight 8, so r*8 + {1,mmm} gives {r+1, mmm}.
    // Subnormals shift the significand right by -r and add nothing to the exponent field.
    assign dshift = (r < 10'sd0) ? (3'd0 - r[2:0]) : 3'd0;
    assign e_off  = (r < 10'sd0) ? 2'b00 : r[1:0];
    assign window = {1'b1, man, 4'b0000} >> dshift;
    assign inc    = window[7] && ((|window[6:0]) || window[8]);
    assign sum    = {1'b0, e_off, 3'b000} + {2'b00, window[11:8]} + {5'b00000, inc};

    always_comb begin
        fp6 = {sign, sum[4:0]};
        sat = 1'b0;
        if (exp_b == BF16_EXP_ONES) begin
            fp6 = {sign, FP6_MAX_MAG};
            sat = 1'b1;
        end else if ((exp_b == '0) || (r < -10'sd4)) begin
            fp6 = {sign, 5'b00000};
        end else if ((r > 10'(FP6_EMAX)) || sum[5]) begin
            fp6 = {sign, FP6_MAX_MAG};
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/mx_fp6_quantizer.sv
// Buffers BLOCK_SIZE BF16 values, derives a shared E8M0 scale and streams FP6 E2M3 out.
// Optional FP6_QUANT_SAT_CNT_EN adds a saturating count of saturated output elements.
module mx_fp6_quantizer
    import fp6_pkg::*;
#(
    parameter int BLOCK_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BF16_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP6_W-1:0]  out_data,
    output logic [7:0]        out_scale,
    output logic              out_last
`ifdef FP6_QUANT_SAT_CNT_EN
    ,
    output logic [15:0]       sat_count
`endif
);

    localparam int            CW       = $clog2(BLOCK_SIZE);
    localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_SIZE - 1);

    quant_state_t          state, state_next;
    logic [CW-1:0]         count;
    logic [7:0]            max_exp, max_exp_next;
    logic [7:0]            scale, scale_next;
    logic                  nan_seen, nan_next;
    logic [BF16_W-1:0]     buf_mem [BLOCK_SIZE];
    logic [BF16_EXP_W-1:0] in_exp;
    logic                  in_fire, out_fire, at_last;
    logic [FP6_W-1:0]      enc_fp6;
`ifdef FP6_QUANT_SAT_CNT_EN
    logic                  enc_sat;
`endif

    assign in_exp       = in_data[BF16_W-2 -: BF16_EXP_W];
    assign at_last      = (count == LAST_IDX);
    assign in_fire      = in_valid && (state == FILL);
    assign out_fire     = out_ready && (state == EMIT);
    assign max_exp_next = (in_exp > max_exp) ? in_exp : max_exp;
    assign nan_next     = nan_seen || (in_exp == BF16_EXP_ONES);

    // Scale includes the beat being accepted so it is ready the cycle EMIT starts.
    always_comb begin
        scale_next = 8'h00;
        if (nan_next) begin
            scale_next = E8M0_NAN;
        end else if (max_exp_next > 8'(FP6_EMAX)) begin
            scale_next = max_exp_next - 8'(FP6_EMAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_fire && at_last) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_fire && at_last) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            max_exp  <= 8'h00;
            nan_seen <= 1'b0;
            scale    <= 8'h00;
        end else if (in_fire) begin
            max_exp  <= max_exp_next;
            nan_seen <= nan_next;
            if (at_last) begin
                count <= '0;
                scale <= scale_next;
            end else begin
                count <= count + 1'b1;
            end
        end else if (out_fire) begin
            if (at_last) begin
                count    <= '0;
                max_exp  <= 8'h00;
                nan_seen <= 1'b0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Element storage needs no reset: an aborted block is simply refilled from index 0.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_mem[count] <= in_data;
        end
    end

    fp6_e2m3_encode u_encode (
        .bf16  (buf_mem[count]),
        .scale (scale),
        .fp6   (enc_fp6),
`ifdef FP6_QUANT_SAT_CNT_EN
        .sat   (enc_sat)
`else
        .sat   ()
`endif
    );

    assign out_data  = (state == EMIT) ? enc_fp6 : '0;
    assign out_last  = (state == EMIT) && at_last;
    assign out_scale = scale;

`ifdef FP6_QUANT_SAT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= 16'h0000;
        end else if (out_fire && enc_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mx_fp6_quantizer.sv
// Self-checking bench for mx_fp6_quantizer with BLOCK_SIZE=4: table of whole blocks,
// then backpressure and asynchronous-reset sequences. Honours FP6_QUANT_SAT_CNT_EN.
module tb_mx_fp6_quantizer;

    localparam int BS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_data;
    logic [7:0]  out_scale;
    logic        out_last;
`ifdef FP6_QUANT_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_sat  = 0;

    always #5 clk = ~clk;

    mx_fp6_quantizer #(.BLOCK_SIZE(BS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_scale (out_scale),
        .out_last  (out_last)
`ifdef FP6_QUANT_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    typedef struct packed {
        logic [3:0][15:0] din;
        logic [7:0]       scale;
        logic [3:0][5:0]  dout;
        logic [7:0]       sat;
    } vec_t;

    vec_t vecs [4];

    function automatic vec_t mk(input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3,
                                input logic [7:0] sc,
                                input logic [5:0] o0, input logic [5:0] o1,
                                input logic [5:0] o2, input logic [5:0] o3,
                                input logic [7:0] s);
        vec_t v;
        v.din   = {d3, d2, d1, d0};
        v.scale = sc;
        v.dout  = {o3, o2, o1, o0};
        v.sat   = s;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers nbeats elements of a vector, checking the block is ready for each.
    task automatic apply_stimulus(input vec_t v, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            check_output("in_ready_fill", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = v.din[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Consumes output beats first..last of a block, checking each against the vector.
    task automatic drain(input vec_t v, input int first, input int last);
        out_ready = 1'b1;
        for (int i = first; i <= last; i++) begin
            check_output("out_valid", 32'(out_valid), 32'd1);
            check_output("in_ready_emit", 32'(in_ready), 32'd0);
            check_output("out_data", 32'(out_data), 32'(v.dout[i]));
            check_output("out_scale", 32'(out_scale), 32'(v.scale));
            check_output("out_last", 32'(out_last), 32'(i == BS - 1));
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic end_of_block();
        check_output("out_valid_idle", 32'(out_valid), 32'd0);
        check_output("in_ready_idle", 32'(in_ready), 32'd1);
`ifdef FP6_QUANT_SAT_CNT_EN
        check_output("sat_count", 32'(sat_count), 32'(exp_sat));
`endif
    endtask

    task automatic run_block(input vec_t v);
        apply_stimulus(v, BS);
        drain(v, 0, BS - 1);
        exp_sat += int'(v.sat);
        end_of_block();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = mk(16'h3F80, 16'h4000, 16'h4080, 16'h3F00, 8'h7F,
                     6'h08, 6'h10, 6'h18, 6'h04, 8'd0);
        vecs[1] = mk(16'h40FC, 16'h3F88, 16'h3F98, 16'h4080, 8'h7F,
                     6'h1F, 6'h08, 6'h0A, 6'h18, 8'd1);
        vecs[2] = mk(16'hC2C0, 16'h3580, 16'h0000, 16'h8000, 8'h83,
                     6'h3C, 6'h00, 6'h00, 6'h20, 8'd0);
        vecs[3] = mk(16'h7FC0, 16'h3F80, 16'h3F80, 16'h3F80, 8'hFF,
                     6'h1F, 6'h00, 6'h00, 6'h00, 8'd1);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        #12;
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_out_last", 32'(out_last), 32'd0);
        check_output("rst_out_scale", 32'(out_scale), 32'd0);
        check_output("rst_out_data", 32'(out_data), 32'd0);
`ifdef FP6_QUANT_SAT_CNT_EN
        check_output("rst_sat_count", 32'(sat_count), 32'd0);
`endif
        rst = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            run_block(vecs[v]);
        end

        // Backpressure: stall after the first output, with a rogue Inf beat offered throughout.
        apply_stimulus(vecs[0], BS);
        in_valid = 1'b1;
        in_data  = 16'h7F80;
        drain(vecs[0], 0, 0);
        for (int k = 0; k < 5; k++) begin
            check_output("stall_out_valid", 32'(out_valid), 32'd1);
            check_output("stall_in_ready", 32'(in_ready), 32'd0);
            check_output("stall_out_data", 32'(out_data), 32'(vecs[0].dout[1]));
            check_output("stall_out_scale", 32'(out_scale), 32'(vecs[0].scale));
            check_output("stall_out_last", 32'(out_last), 32'd0);
            tick();
        end
        drain(vecs[0], 1, BS - 1);
        in_valid = 1'b0;
        end_of_block();
        run_block(vecs[1]);

        // Reset during FILL after two large-exponent beats must leave no trace.
        apply_stimulus(vecs[2], 2);
        rst = 1'b1;
        #2;
        check_output("rstfill_in_ready", 32'(in_ready), 32'd1);
        check_output("rstfill_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        exp_sat = 0;
        tick();
        run_block(vecs[0]);

        // Reset during EMIT of a NaN block must clear the NaN flag and scale.
        apply_stimulus(vecs[3], BS);
        drain(vecs[3], 0, 1);
        rst = 1'b1;
        #2;
        check_output("rstemit_in_ready", 32'(in_ready), 32'd1);
        check_output("rstemit_out_valid", 32'(out_valid), 32'd0);
        check_output("rstemit_out_last", 32'(out_last), 32'd0);
        check_output("rstemit_out_scale", 32'(out_scale), 32'd0);
        rst = 1'b0;
        exp_sat = 0;
        tick();
        run_block(vecs[0]);
        run_block(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
